mem_master: RTL

Synchronous initiator for the single-port register-file memory (`we`/`addr`/`write`/`read` interface, registered read data). It accepts client requests over a valid/ready handshake and drives the memory port. Writes are single-beat. Reads are bursts of 1 to 2^N consecutive addresses. Each read word is returned over a back-pressured response channel. It sits between a client (CPU/test sequencer) and the `memory` instance.

---
 rtl/mem_master.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_master.sv
// mem_master: client-facing initiator for a single-port register-file memory.
// Accepts write / read-burst requests over a valid/ready handshake, drives the
// memory port and returns each read word on a back-pressured response channel.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (ready only while idle)
//   req_we/req_addr/req_wdata/req_len
//                             write flag, start address, write data and
//                             burst length minus one
//   resp_valid/resp_ready/resp_rdata
//                             read-word response channel
//   mem_we/mem_addr/mem_write/mem_read
//                             memory port; read data arrives one cycle late
//   busy                      any state other than idle
//   op_count                  completed transactions, wraps at 2^16
module mem_master #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  input  logic [N-1:0] req_len,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_rdata,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_write,
  input  logic [N-1:0] mem_read,
  output logic         busy,
  output logic [15:0]  op_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N-1:0]       r_addr;
  logic [N-1:0]       w_addr_nxt;
  logic [N-1:0]       r_len;
  logic [N-1:0]       w_len_nxt;
  logic               r_req_ready;
  logic               w_req_ready_nxt;
  logic               r_resp_valid;
  logic               w_resp_valid_nxt;
  logic [N-1:0]       r_resp_rdata;
  logic [N-1:0]       w_resp_rdata_nxt;
  logic               r_mem_we;
  logic               w_mem_we_nxt;
  logic [N-1:0]       r_mem_addr;
  logic [N-1:0]       w_mem_addr_nxt;
  logic [N-1:0]       r_mem_write;
  logic [N-1:0]       w_mem_write_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic [CNT_W-1:0]   r_op_count;
  logic [CNT_W-1:0]   w_op_count_nxt;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_write  <= '0;
      r_busy       <= 1'b0;
      r_op_count   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_len        <= w_len_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_busy       <= w_busy_nxt;
      r_op_count   <= w_op_count_nxt;
    end
  end

  // Next state and next output values. Memory port values are set on the
  // edge entering WR / RD_ADDR so they are presented during that state.
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_len_nxt        = r_len;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_rdata_nxt = r_resp_rdata;
    w_mem_we_nxt     = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_write_nxt  = r_mem_write;
    w_op_count_nxt   = r_op_count;

    case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_addr_nxt     = req_addr;
          w_len_nxt      = req_len;
          w_mem_addr_nxt = req_addr;
          if (req_we) begin
            w_state_nxt     = S_WR;
            w_mem_we_nxt    = 1'b1;
            w_mem_write_nxt = req_wdata;
          end else begin
            w_state_nxt = S_RD_ADDR;
          end
        end
      end
      S_WR: begin
        w_op_count_nxt = r_op_count + CNT_W'(1);
        w_state_nxt    = S_IDLE;
      end
      S_RD_ADDR: begin
        w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        w_resp_rdata_nxt = mem_read;
        w_resp_valid_nxt = 1'b1;
        w_state_nxt      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          if (r_len == '0) begin
            w_op_count_nxt = r_op_count + CNT_W'(1);
            w_state_nxt    = S_IDLE;
          end else begin
            // Address wraps naturally at 2^N.
            w_len_nxt      = r_len - N'(1);
            w_addr_nxt     = r_addr + N'(1);
            w_mem_addr_nxt = r_addr + N'(1);
            w_state_nxt    = S_RD_ADDR;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_req_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_write  = r_mem_write;
  assign busy       = r_busy;
  assign op_count   = r_op_count;

endmodule
